// File: rtl/mem_wb_stage.sv
// Memory / write-back stage: ALU results write back one cycle after acceptance, loads go
// through a blocking data-cache read with optional timeout, then extend and write back.
module mem_wb_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               writeEnableIn,
  input  logic               dataCacheReadEnableIn,
  input  logic [2:0]         loadType,
  input  logic [RADDR_W-1:0] writeBackAddrIn,
  input  logic [DATA_W-1:0]  aluResultIn,
  output logic               stall,
  output logic               cache_req,
  output logic [DATA_W-1:0]  cache_addr,
  input  logic [DATA_W-1:0]  cache_rdata,
  input  logic               cache_ack,
  output logic               wb_en,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] LdB  = 3'b000;
  localparam logic [2:0] LdH  = 3'b001;
  localparam logic [2:0] LdW  = 3'b010;
  localparam logic [2:0] LdBu = 3'b100;
  localparam logic [2:0] LdHu = 3'b101;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]  cache_addr_q, cache_addr_d;
  logic               wb_en_q, wb_en_d;
  logic [RADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               err_q, err_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               we_q, we_d;
  logic [2:0]         lt_q, lt_d;
  logic [1:0]         off_q, off_d;

  logic               load_bad;
  logic               expired;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [DATA_W-1:0]  load_data;

  // Illegal funct3 or an access that straddles its natural alignment.
  always_comb begin
    load_bad = 1'b0;
    unique case (loadType)
      LdB, LdBu: load_bad = 1'b0;
      LdH, LdHu: load_bad = aluResultIn[0];
      LdW:       load_bad = |aluResultIn[1:0];
      default:   load_bad = 1'b1;
    endcase
  end

  assign byte_sel = cache_rdata[8*off_q +: 8];
  assign half_sel = cache_rdata[16*off_q[1] +: 16];

  always_comb begin
    load_data = cache_rdata;
    unique case (lt_q)
      LdB:     load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LdBu:    load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LdH:     load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LdHu:    load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = cache_rdata;
    endcase
  end

  // TIMEOUT == 0 disables the abort path entirely.
  assign expired = (TIMEOUT != 0) && (cnt_q == CntMax);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cache_addr_d = cache_addr_q;
    wb_en_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    err_d        = 1'b0;
    rd_d         = rd_q;
    we_d         = we_q;
    lt_d         = lt_q;
    off_d        = off_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!dataCacheReadEnableIn) begin
            if (writeEnableIn && (writeBackAddrIn != '0)) begin
              wb_en_d   = 1'b1;
              wb_addr_d = writeBackAddrIn;
              wb_data_d = aluResultIn;
            end
          end else if (load_bad) begin
            err_d = 1'b1;
          end else begin
            rd_d         = writeBackAddrIn;
            we_d         = writeEnableIn;
            lt_d         = loadType;
            off_d        = aluResultIn[1:0];
            cache_addr_d = {aluResultIn[DATA_W-1:2], 2'b00};
            cnt_d        = '0;
            state_d      = StWait;
          end
        end
      end
      StWait: begin
        // An ack in the expiry cycle still completes the load normally.
        if (cache_ack) begin
          state_d = StIdle;
          if (we_q && (rd_q != '0)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = load_data;
          end
        end else if (expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cache_addr_q <= '0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      err_q        <= 1'b0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      lt_q         <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cache_addr_q <= cache_addr_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      err_q        <= err_d;
      rd_q         <= rd_d;
      we_q         <= we_d;
      lt_q         <= lt_d;
      off_q        <= off_d;
    end
  end

  // Request is a pure function of state so reset drops it asynchronously.
  assign stall      = (state_q == StWait);
  assign cache_req  = (state_q == StWait);
  assign cache_addr = cache_addr_q;
  assign wb_en      = wb_en_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign err        = err_q;

endmodule
